ga_term_ctrl: RTL



---
 rtl/ga_term_if.sv | 32 +++
 rtl/ga_term_ctrl.sv | 69 ++++++
 2 files changed

// File: rtl/ga_term_if.sv
// ga_term_if: tick/best inputs and run-status outputs between the GA pipeline and ga_term_ctrl.
interface ga_term_if #(
  parameter int FIT_WIDTH   = 27,
  parameter int CHROM_WIDTH = 8,
  parameter int GEN_WIDTH   = 16,
  parameter int STALL_WIDTH = 8
);
  logic                   start;
  logic                   gen_tick;
  logic [FIT_WIDTH-1:0]   best_fit;
  logic [CHROM_WIDTH-1:0] best;
  logic                   ga_enable;
  logic                   done;
  logic [1:0]             done_reason;
  logic [GEN_WIDTH-1:0]   gen_count;
  logic [STALL_WIDTH-1:0] stall_count;
  logic [FIT_WIDTH-1:0]   result_fit;
  logic [CHROM_WIDTH-1:0] result_chrom;
`ifdef GA_TARGET_FIT_EN
  logic [FIT_WIDTH-1:0]   target_fit;
  logic                   target_valid;
  modport master (output start, gen_tick, best_fit, best, target_fit, target_valid,
                  input ga_enable, done, done_reason, gen_count, stall_count, result_fit, result_chrom);
  modport slave  (input start, gen_tick, best_fit, best, target_fit, target_valid,
                  output ga_enable, done, done_reason, gen_count, stall_count, result_fit, result_chrom);
`else
  modport master (output start, gen_tick, best_fit, best,
                  input ga_enable, done, done_reason, gen_count, stall_count, result_fit, result_chrom);
  modport slave  (input start, gen_tick, best_fit, best,
                  output ga_enable, done, done_reason, gen_count, stall_count, result_fit, result_chrom);
`endif
endinterface

// File: rtl/ga_term_ctrl.sv
// ga_term_ctrl: GA run controller stopping on max generations or stall; GA_TARGET_FIT_EN adds target-fitness stop.
module ga_term_ctrl #(
  parameter int FIT_WIDTH   = 27,
  parameter int CHROM_WIDTH = 8,
  parameter int GEN_WIDTH   = 16,
  parameter int MAX_GEN     = 1000,
  parameter int STALL_WIDTH = 8,
  parameter int STALL_LIMIT = 64
) (
  input logic clk,
  input logic reset,
  ga_term_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [GEN_WIDTH-1:0] gen_nx;
  logic [STALL_WIDTH-1:0] stall_nx;
  logic improve, hit_tgt;
  logic [1:0] reason_nx;
  always_comb begin
    gen_nx = bus.gen_count + 1'b1;
    improve = bus.best_fit > bus.result_fit;
    stall_nx = improve ? '0 : (&bus.stall_count ? bus.stall_count : bus.stall_count + 1'b1);
`ifdef GA_TARGET_FIT_EN
    hit_tgt = bus.target_valid && bus.best_fit >= bus.target_fit;
`else
    hit_tgt = 1'b0;
`endif
    reason_nx = hit_tgt ? 2'd3 :
                gen_nx == GEN_WIDTH'(MAX_GEN) ? 2'd1 :
                stall_nx == STALL_WIDTH'(STALL_LIMIT) ? 2'd2 : 2'd0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bus.ga_enable <= 1'b0;
      bus.done <= 1'b0;
      bus.done_reason <= '0;
      bus.gen_count <= '0;
      bus.stall_count <= '0;
      bus.result_fit <= '0;
      bus.result_chrom <= '0;
    end else if (state == RUN) begin
      if (bus.gen_tick) begin
        bus.gen_count <= gen_nx;
        bus.stall_count <= stall_nx;
        if (improve) begin
          bus.result_fit <= bus.best_fit;
          bus.result_chrom <= bus.best;
        end
        if (reason_nx != 2'd0) begin
          state <= DONE;
          bus.done <= 1'b1;
          bus.ga_enable <= 1'b0;
          bus.done_reason <= reason_nx;
        end
      end
    end else if (bus.start) begin
      state <= RUN;
      bus.ga_enable <= 1'b1;
      bus.done <= 1'b0;
      bus.done_reason <= '0;
      bus.gen_count <= '0;
      bus.stall_count <= '0;
      bus.result_fit <= '0;
      bus.result_chrom <= '0;
    end
  end
endmodule
